// File: rtl/cam_pwr_seq_pkg.sv
// Shared types, limits and timing helpers for the camera power-up sequencer.
package cam_pwr_seq_pkg;

  localparam int unsigned CAM_MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PWDN = 2'd1,
    RST  = 2'd2,
    INIT = 2'd3
  } cam_seq_state_e;

  // Microseconds to clock cycles; freq must be a whole number of MHz.
  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned freq);
    return us * (freq / 32'd1_000_000);
  endfunction

endpackage

// File: rtl/cam_pwr_seq_if.sv
// Control/status bundle between camera shell (master) and power sequencer (slave).
interface cam_pwr_seq_if #(
  parameter int unsigned N = 1
);
  logic [N-1:0] en;
  logic [N-1:0] pwdn_req;
  logic [N-1:0] reinit;
  logic [N-1:0] cam_pwdn;
  logic [N-1:0] cam_rst_n;
  logic [N-1:0] ready;
  logic         busy;

  modport master (
    output en, pwdn_req, reinit,
    input  cam_pwdn, cam_rst_n, ready, busy
  );

  modport slave (
    input  en, pwdn_req, reinit,
    output cam_pwdn, cam_rst_n, ready, busy
  );
endinterface

// File: rtl/cam_pwr_seq_timer.sv
// Shared phase timer: loadable down-counter that parks at zero.
module cam_pwr_seq_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cam_pwr_seq.sv
// Multi-camera PWDN/RESETB sequencer: brings channels up one at a time with datasheet
// hold times, supports run-time kill and re-initialisation, and flags per-channel ready.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int unsigned NUM_CAM     = 1,
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned T_PWDN_US   = 1000,
  parameter int unsigned T_RST_US    = 1000,
  parameter int unsigned T_INIT_US   = 20000
) (
  input  logic          clk,
  input  logic          rst_n,
  cam_pwr_seq_if.slave  bus
);

  localparam int unsigned T_PWDN  = us_to_cyc(T_PWDN_US, CLK_FREQ_HZ);
  localparam int unsigned T_RST   = us_to_cyc(T_RST_US, CLK_FREQ_HZ);
  localparam int unsigned T_INIT  = us_to_cyc(T_INIT_US, CLK_FREQ_HZ);
  localparam int unsigned T_MAX_A = (T_PWDN > T_RST) ? T_PWDN : T_RST;
  localparam int unsigned T_MAX   = (T_MAX_A > T_INIT) ? T_MAX_A : T_INIT;
  localparam int unsigned TMR_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned CH_W    = (NUM_CAM > 1) ? $clog2(NUM_CAM) : 1;

  if (CLK_FREQ_HZ % 1_000_000 != 0) begin : g_bad_freq
    $error("cam_pwr_seq: CLK_FREQ_HZ must be a whole number of MHz");
  end
  if (NUM_CAM < 1 || NUM_CAM > CAM_MAX_CH) begin : g_bad_num
    $error("cam_pwr_seq: NUM_CAM out of range");
  end
  if (T_PWDN == 0 || T_RST == 0 || T_INIT == 0) begin : g_bad_time
    $error("cam_pwr_seq: phase times must be at least one cycle");
  end

  cam_seq_state_e state, state_d;
  logic [CH_W-1:0]    cur_ch, cur_d, pick;
  logic [NUM_CAM-1:0] kill, rdy_keep, wants;
  logic [NUM_CAM-1:0] ready_d, pwdn_d, rst_n_d;
  logic               tmr_load, tmr_clr, tmr_zero, set_rdy;
  logic [TMR_W-1:0]   tmr_val;

  // A reinit pulse drops ready in the same evaluation, so the channel is eligible at once.
  always_comb begin
    kill     = ~bus.en | bus.pwdn_req;
    rdy_keep = bus.ready & ~kill & ~bus.reinit;
    wants    = ~kill & ~rdy_keep;
    pick     = '0;
    for (int i = int'(NUM_CAM) - 1; i >= 0; i--) begin
      if (wants[i]) pick = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur_ch <= '0;
    end else begin
      state  <= state_d;
      cur_ch <= cur_d;
    end
  end

  always_comb begin
    state_d  = state;
    cur_d    = cur_ch;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_clr  = 1'b0;
    set_rdy  = 1'b0;
    case (state)
      IDLE: if (|wants) begin
        state_d  = PWDN;
        cur_d    = pick;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_PWDN - 1);
      end
      PWDN: if (tmr_zero) begin
        state_d  = RST;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_RST - 1);
      end
      RST: if (tmr_zero) begin
        state_d  = INIT;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_INIT - 1);
      end
      INIT: if (tmr_zero) begin
        state_d = IDLE;
        set_rdy = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Killing the channel in flight aborts the sequence on this edge.
    if (state != IDLE && kill[cur_ch]) begin
      state_d  = IDLE;
      tmr_load = 1'b0;
      tmr_clr  = 1'b1;
      set_rdy  = 1'b0;
    end
  end

  // Pin/ready targets follow the next state so the outputs can be registered.
  always_comb begin
    ready_d = rdy_keep;
    pwdn_d  = '1;
    rst_n_d = '0;
    for (int i = 0; i < int'(NUM_CAM); i++) begin
      if (set_rdy && cur_ch == CH_W'(i)) ready_d[i] = 1'b1;
      pwdn_d[i]  = ~(ready_d[i] | (cur_d == CH_W'(i) && (state_d == RST || state_d == INIT)));
      rst_n_d[i] = ready_d[i] | (cur_d == CH_W'(i) && state_d == INIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cam_pwdn  <= '1;
      bus.cam_rst_n <= '0;
      bus.ready     <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.cam_pwdn  <= pwdn_d;
      bus.cam_rst_n <= rst_n_d;
      bus.ready     <= ready_d;
      bus.busy      <= (state_d != IDLE);
    end
  end

  cam_pwr_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .clr      (tmr_clr),
    .zero     (tmr_zero)
  );

endmodule
